// File: rtl/acorn_phase_sequencer_pkg.sv
// ACORN-128 phase sequencer shared types and step budgets.
// Optional abort input is enabled by defining ACORN_SEQ_ABORT_EN.
package acorn_pkg;

    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_INIT  = 3'd1,
        PH_AD    = 3'd2,
        PH_MSG   = 3'd3,
        PH_FINAL = 3'd4,
        PH_DONE  = 3'd5
    } phase_e;

    typedef enum logic [2:0] {
        SRC_ZERO = 3'd0,
        SRC_ONE  = 3'd1,
        SRC_KEY  = 3'd2,
        SRC_IV   = 3'd3,
        SRC_KEY1 = 3'd4,
        SRC_AD   = 3'd5,
        SRC_PT   = 3'd6,
        SRC_CTKS = 3'd7
    } mbit_src_e;

    localparam int INIT_STEPS  = 1792;
    localparam int PAD_STEPS   = 256;
    localparam int FINAL_STEPS = 768;
    localparam int TAG_BITS    = 128;
    localparam int KEY_BITS    = 128;

    function automatic logic is_busy(phase_e p);
        return (p == PH_INIT) || (p == PH_AD) ||
               (p == PH_MSG)  || (p == PH_FINAL);
    endfunction

endpackage

// File: rtl/acorn_phase_sequencer_if.sv
// Step handshake between the phase sequencer and the state-update datapath.
// Sequencer drives the control word (master); datapath returns ready.
interface acorn_phase_sequencer_if #(
    parameter int IDX_W = 16
);
    import acorn_pkg::*;

    logic             step_valid;
    logic             step_ready;
    logic             ca;
    logic             cb;
    mbit_src_e        mbit_src;
    logic [IDX_W-1:0] bit_idx;
    logic             ks_use;
    logic             tag_cap;

    modport master (
        output step_valid, ca, cb, mbit_src, bit_idx, ks_use, tag_cap,
        input  step_ready
    );

    modport slave (
        input  step_valid, ca, cb, mbit_src, bit_idx, ks_use, tag_cap,
        output step_ready
    );

endinterface

// File: rtl/acorn_phase_sequencer_step_counter.sv
// Per-phase step counter: advances on each retired step and wraps
// to zero on the terminal step so the next phase starts at 0.
module acorn_step_counter #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] len,
    output logic [W-1:0] count,
    output logic         last
);

    assign last = (count == len - W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || (en && last)) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/acorn_phase_sequencer.sv
// ACORN-128 step scheduler: INIT -> AD -> MSG -> FINAL control words.
// Define ACORN_SEQ_ABORT_EN to add a synchronous abort input.
module acorn_phase_sequencer
    import acorn_pkg::*;
#(
    parameter int LEN_W = 16,
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             decrypt,
    input  logic [LEN_W-1:0] ad_len,
    input  logic [LEN_W-1:0] msg_len,
`ifdef ACORN_SEQ_ABORT_EN
    input  logic             abort,
`endif
    acorn_phase_sequencer_if.master step,
    output phase_e           phase,
    output logic             busy,
    output logic             done
);

    // Wide enough for len+256 without wrap and for the 1792 INIT steps.
    localparam int CNT_W = (LEN_W + 1 > 12) ? LEN_W + 1 : 12;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t C_INIT  = cnt_t'(INIT_STEPS);
    localparam cnt_t C_FINAL = cnt_t'(FINAL_STEPS);
    localparam cnt_t C_PAD   = cnt_t'(PAD_STEPS);
    localparam cnt_t C_TAIL  = cnt_t'(PAD_STEPS / 2);
    localparam cnt_t C_KEY   = cnt_t'(KEY_BITS);
    localparam cnt_t C_IVEND = cnt_t'(2 * KEY_BITS);
    localparam cnt_t C_CAP   = cnt_t'(FINAL_STEPS - TAG_BITS);

    phase_e           ph_q, ph_d;
    logic             dec_q;
    logic [LEN_W-1:0] ad_q, msg_q;

    cnt_t i, len, ad_n, msg_n;
    logic last, retire, clear, valid, abort_s;

    logic             v_ca, v_cb, v_ks, v_tag;
    mbit_src_e        v_src;
    logic [IDX_W-1:0] v_idx;

`ifdef ACORN_SEQ_ABORT_EN
    assign abort_s = abort & busy;
`else
    assign abort_s = 1'b0;
`endif

    assign ad_n   = cnt_t'(ad_q);
    assign msg_n  = cnt_t'(msg_q);
    assign busy   = is_busy(ph_q);
    assign valid  = busy;
    assign done   = (ph_q == PH_DONE);
    assign phase  = ph_q;
    assign retire = valid & step.step_ready;
    assign clear  = (ph_q == PH_IDLE) | abort_s;

    acorn_step_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .en    (retire),
        .len   (len),
        .count (i),
        .last  (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_q <= PH_IDLE;
        end else begin
            ph_q <= ph_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q <= 1'b0;
            ad_q  <= '0;
            msg_q <= '0;
        end else if (ph_q == PH_IDLE && start) begin
            dec_q <= decrypt;
            ad_q  <= ad_len;
            msg_q <= msg_len;
        end
    end

    always_comb begin
        ph_d  = ph_q;
        len   = C_INIT;
        v_ca  = 1'b0;
        v_cb  = 1'b0;
        v_ks  = 1'b0;
        v_tag = 1'b0;
        v_src = SRC_ZERO;
        v_idx = '0;
        unique case (ph_q)
            PH_IDLE: begin
                if (start) ph_d = PH_INIT;
            end
            PH_INIT: begin
                len  = C_INIT;
                v_ca = 1'b1;
                v_cb = 1'b1;
                if (retire && last) ph_d = PH_AD;
                if (i < C_KEY) begin
                    v_src = SRC_KEY;
                    v_idx = IDX_W'(i[6:0]);
                end else if (i < C_IVEND) begin
                    v_src = SRC_IV;
                    v_idx = IDX_W'(i[6:0]);
                end else if (i == C_IVEND) begin
                    v_src = SRC_KEY1;
                end else begin
                    v_src = SRC_KEY;
                    v_idx = IDX_W'(i[6:0]);
                end
            end
            PH_AD: begin
                len  = ad_n + C_PAD;
                v_cb = 1'b1;
                v_ca = (i < ad_n + C_TAIL);
                if (retire && last) ph_d = PH_MSG;
                if (i < ad_n) begin
                    v_src = SRC_AD;
                    v_idx = IDX_W'(i);
                end else if (i == ad_n) begin
                    v_src = SRC_ONE;
                end
            end
            PH_MSG: begin
                len  = msg_n + C_PAD;
                v_ca = (i < msg_n + C_TAIL);
                if (retire && last) ph_d = PH_FINAL;
                if (i < msg_n) begin
                    v_src = dec_q ? SRC_CTKS : SRC_PT;
                    v_idx = IDX_W'(i);
                    v_ks  = 1'b1;
                end else if (i == msg_n) begin
                    v_src = SRC_ONE;
                end
            end
            PH_FINAL: begin
                len  = C_FINAL;
                v_ca = 1'b1;
                v_cb = 1'b1;
                if (retire && last) ph_d = PH_DONE;
                if (i >= C_CAP) begin
                    v_tag = 1'b1;
                    v_idx = IDX_W'(i - C_CAP);
                end
            end
            PH_DONE: begin
                ph_d = PH_IDLE;
            end
            default: begin
                ph_d = PH_IDLE;
            end
        endcase
        if (abort_s) ph_d = PH_IDLE;
    end

    assign step.step_valid = valid;
    assign step.ca         = v_ca;
    assign step.cb         = v_cb;
    assign step.mbit_src   = v_src;
    assign step.bit_idx    = v_idx;
    assign step.ks_use     = v_ks;
    assign step.tag_cap    = v_tag;

endmodule

// File: tb/tb_acorn_phase_sequencer.sv
// Scoreboard bench for acorn_phase_sequencer with a step-list reference model.
// Runs the default build (ACORN_SEQ_ABORT_EN undefined).
module tb_acorn_phase_sequencer;
    import acorn_pkg::*;

    typedef struct {
        bit        ca;
        bit        cb;
        mbit_src_e src;
        int        idx;
        bit        idx_care;
        bit        ks;
        bit        tag;
        phase_e    ph;
    } step_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        decrypt = 1'b0;
    logic [15:0] ad_len = '0;
    logic [15:0] msg_len = '0;
    phase_e      phase;
    logic        busy;
    logic        done;

    acorn_phase_sequencer_if #(.IDX_W(16)) sif ();

    acorn_phase_sequencer #(
        .LEN_W(16),
        .IDX_W(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .decrypt (decrypt),
        .ad_len  (ad_len),
        .msg_len (msg_len),
        .step    (sif),
        .phase   (phase),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    step_t q[$];
    int tests = 0;
    int fails = 0;
    int retired = 0;
    int tag_n = 0;
    int done_cnt = 0;
    int cyc = 0;
    int last_ret = 0;

    // Reference: expected step list for one run, straight from the phase rules.
    task automatic build(int ad, int msg, bit dec);
        step_t e;
        q.delete();
        for (int i = 0; i < 1792; i++) begin
            e = '{ca: 1, cb: 1, src: SRC_KEY, idx: i % 128,
                  idx_care: 1, ks: 0, tag: 0, ph: PH_INIT};
            if (i >= 128 && i < 256) e.src = SRC_IV;
            if (i == 256) begin
                e.src = SRC_KEY1;
                e.idx = 0;
            end
            q.push_back(e);
        end
        for (int i = 0; i < ad + 256; i++) begin
            e = '{ca: (i < ad + 128), cb: 1, src: SRC_ZERO, idx: i,
                  idx_care: (i < ad), ks: 0, tag: 0, ph: PH_AD};
            if (i < ad) e.src = SRC_AD;
            else if (i == ad) e.src = SRC_ONE;
            q.push_back(e);
        end
        for (int i = 0; i < msg + 256; i++) begin
            e = '{ca: (i < msg + 128), cb: 0, src: SRC_ZERO, idx: i,
                  idx_care: (i < msg), ks: (i < msg), tag: 0, ph: PH_MSG};
            if (i < msg) e.src = dec ? SRC_CTKS : SRC_PT;
            else if (i == msg) e.src = SRC_ONE;
            q.push_back(e);
        end
        for (int i = 0; i < 768; i++) begin
            e = '{ca: 1, cb: 1, src: SRC_ZERO, idx: i - 640,
                  idx_care: (i >= 640), ks: 0, tag: (i >= 640), ph: PH_FINAL};
            q.push_back(e);
        end
    endtask

    // Monitor: compares each retired step and checks stall stability.
    initial begin
        logic [25:0] cur, held;
        bit stalled = 0;
        step_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                stalled = 0;
            end else begin
                cur = {sif.ca, sif.cb, sif.mbit_src, sif.bit_idx,
                       sif.ks_use, sif.tag_cap, phase};
                if (sif.step_valid) begin
                    if (stalled) begin
                        tests++;
                        if (cur !== held) begin
                            fails++;
                            $display("FAIL stall_hold: got %h required %h", cur, held);
                        end
                    end
                    if (sif.step_ready) begin
                        tests++;
                        if (q.size() == 0) begin
                            fails++;
                            $display("FAIL extra_step: got step %0d, required none", retired);
                        end else begin
                            e = q.pop_front();
                            if (sif.ca !== e.ca || sif.cb !== e.cb ||
                                sif.mbit_src !== e.src ||
                                sif.ks_use !== e.ks || sif.tag_cap !== e.tag ||
                                phase !== e.ph ||
                                (e.idx_care && sif.bit_idx !== 16'(e.idx))) begin
                                fails++;
                                $display("FAIL step %0d: got ca=%0b cb=%0b src=%0d idx=%0d ks=%0b tag=%0b ph=%0d required ca=%0b cb=%0b src=%0d idx=%0d ks=%0b tag=%0b ph=%0d",
                                         retired, sif.ca, sif.cb, sif.mbit_src,
                                         sif.bit_idx, sif.ks_use, sif.tag_cap, phase,
                                         e.ca, e.cb, e.src, e.idx, e.ks, e.tag, e.ph);
                            end
                        end
                        retired++;
                        last_ret = cyc;
                        if (sif.tag_cap) tag_n++;
                        stalled = 0;
                    end else begin
                        held = cur;
                        stalled = 1;
                    end
                end else begin
                    stalled = 0;
                end
                if (done) begin
                    done_cnt++;
                    tests++;
                    if (cyc - last_ret != 1 || q.size() != 0 || busy) begin
                        fails++;
                        $display("FAIL done_timing: got gap=%0d left=%0d busy=%0b required gap=1 left=0 busy=0",
                                 cyc - last_ret, q.size(), busy);
                    end
                end
            end
        end
    end

    task automatic check_idle(string name);
        logic [30:0] w;
        w = {sif.step_valid, sif.ca, sif.cb, sif.mbit_src, sif.bit_idx,
             sif.ks_use, sif.tag_cap, phase, busy, done};
        tests++;
        if (w !== '0) begin
            fails++;
            $display("FAIL %s: got outputs %h required 0", name, w);
        end
    endtask

    task automatic run(int ad, int msg, bit dec, int low_pct, bit poke);
        int d0;
        int c;
        build(ad, msg, dec);
        retired = 0;
        tag_n = 0;
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        decrypt = dec;
        ad_len = 16'(ad);
        msg_len = 16'(msg);
        @(posedge clk); #1;
        start = 1'b0;
        ad_len = 16'($urandom);
        msg_len = 16'($urandom);
        decrypt = ~dec;
        c = 0;
        while (done_cnt == d0 && c < 12000) begin
            sif.step_ready = ($urandom_range(99) >= low_pct);
            start = (poke && c == 700);
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        sif.step_ready = 1'b1;
        tests++;
        if (done_cnt == d0) begin
            fails++;
            $display("FAIL run_timeout: got no done after %0d cycles, required done", c);
        end
        tests++;
        if (retired != 3072 + ad + msg) begin
            fails++;
            $display("FAIL retired_total: got %0d required %0d", retired, 3072 + ad + msg);
        end
        tests++;
        if (tag_n != 128) begin
            fails++;
            $display("FAIL tag_count: got %0d required 128", tag_n);
        end
    endtask

    initial begin
        int d0;
        int c;
        sif.step_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_state");
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle("idle_after_reset");

        run(0, 0, 0, 0, 0);
        run(8, 16, 0, 0, 0);
        run(0, 4, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            run($urandom_range(400), $urandom_range(400),
                1'($urandom_range(1)), 30, 1);
        end

        // Reset in the middle of INIT at step 1000.
        build(0, 0, 0);
        retired = 0;
        d0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        ad_len = 16'd0;
        msg_len = 16'd0;
        decrypt = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while (retired < 1000 && c < 3000) begin
            @(posedge clk);
            c++;
        end
        #1;
        tests++;
        if (retired != 1000 || phase !== PH_INIT) begin
            fails++;
            $display("FAIL mid_run_pos: got step %0d phase %0d required 1000 INIT", retired, phase);
        end
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_reset_mid_run");
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("idle_after_mid_reset");
        tests++;
        if (done_cnt != d0) begin
            fails++;
            $display("FAIL no_done_on_reset: got %0d done pulses required 0", done_cnt - d0);
        end

        run(5, 3, 0, 30, 0);
        run(300, 0, 1, 30, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
